module_teclado_emulador: RTL and testbench
==========================================

Name: module_teclado_emulador

Overview:
- Synthesizable 4x4 matrix-keypad emulator: the key-matrix side of the column-drive/row-sense interface that the keypad scanner drives.
- Accepts a key-press request over a valid/ready handshake.
- Plays out a timed press: contact bounce, hold, release bounce, then an inter-key gap.
- Drives the row lines in response to the scanner's column drive. Used for board self-test and closed-loop scanner verification.

Parameters:
- BOUNCE_CYCLES, 8: length of each bounce phase in clk cycles; 0 skips both bounce phases.
- BOUNCE_PERIOD, 2: cycles between contact toggles while bouncing (>=1).
- HOLD_CYCLES, 16: cycles of stable contact (>=1).
- GAP_CYCLES, 8: cycles of guaranteed release after bounce-out, before the next request is accepted (>=0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_code  in  4  requested key: [3:2] row index, [1:0] column index
- key_valid  in  1  request valid
- key_ready  out  1  emulator idle, can accept a request
- col  in  4  column drive from scanner, active-high
- fila  out  4  row sense to scanner, active-high, one-hot or zero
- pressed  out  1  current contact state
- busy  out  1  request in progress
- done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, contact=0, latched code=0, counters=0. Outputs become fila=0, pressed=0, busy=0, done=0, key_ready=1.
- Reset mid-operation aborts immediately; no done pulse is issued.
- States, in order: IDLE -> BOUNCE_IN -> HOLD -> BOUNCE_OUT -> GAP -> IDLE.
- Phase counter k restarts at 0 on entry to every state. Each state lasts exactly its parameter count in cycles.
- BOUNCE_CYCLES=0: BOUNCE_IN and BOUNCE_OUT are skipped (IDLE->HOLD, HOLD->GAP).
- GAP_CYCLES=0: GAP is skipped (BOUNCE_OUT->IDLE).
- IDLE:
  - key_ready=1, contact=0.
  - Accept when key_valid && key_ready at an edge: latch key_code, go to next state on that edge.
  - key_valid without ready is ignored and held by the requester.
- BOUNCE_IN: contact=1 when floor(k/BOUNCE_PERIOD) is even, 0 when odd.
- HOLD: contact=1.
- BOUNCE_OUT: contact=0 when floor(k/BOUNCE_PERIOD) is even, 1 when odd.
- GAP: contact=0. On exit, done=1 for exactly one cycle, aligned with the first IDLE cycle.
- Latency and register outputs:
  - contact, state and latched code are registered.
  - The first BOUNCE_IN (or HOLD) cycle, with pressed=1, follows the accepting edge.
  - pressed mirrors contact.
  - busy = (state != IDLE); key_ready = (state == IDLE).
- fila is combinational from the registered state plus col:
  - fila = contact && col[c] ? onehot(r) : 4'b0000, where r and c come from the latched code.
  - Same-cycle response to col changes; no registered delay on fila.
- col robustness:
  - Only col[c] is examined; other col bits are don't-care.
  - col=0 gives fila=0 even while contact=1.
  - Multi-hot col containing c still gives onehot(r).
- key_code and key_valid changes while busy have no effect.
- Total busy duration per request: 2*BOUNCE_CYCLES + HOLD_CYCLES + GAP_CYCLES cycles (defaults: 40).
- Counters are sized with $clog2(max(param,2)) bits. No wrap occurs: every state exits at k == param-1.

Decomposition:
- Package teclado_pkg:
  - state enum emu_state_t {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP}
  - key_code_t (4-bit packed {row[1:0], col[1:0]})
  - function row_onehot(logic [1:0]) -> logic [3:0]
  - KEYPAD_ROWS/KEYPAD_COLS = 4 constants, shared with the scanner
- One natural sub-module: module_teclado_fase_timer.
  - Loadable phase counter with terminal-count flag and bounce-toggle output.
  - Instanced once; the FSM loads the phase length on each state entry.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with key_valid=1 -> fila=0, pressed=0, busy=0, key_ready=1, no done. Release rst -> request accepted on the next edge.
2. Basic press, defaults: key_code=4'b0110, col=4'b0100 throughout -> fila sequence over the 8 BOUNCE_IN cycles is 0010,0010,0000,0000,0010,0010,0000,0000; then 16 cycles of 0010; BOUNCE_OUT 0000,0000,0010,0010,0000,0000,0010,0010; 8 cycles of 0000; done pulse at cycle 41 after accept; busy high exactly 40 cycles.
3. Scanning response during HOLD for key_code=4'b1101: col 0001 -> fila 0000; 0010 -> 1000; 0100 -> 0000; 1000 -> 0000; 0000 -> 0000; 1111 -> 1000; each change visible in the same cycle.
4. Back-to-back: key_valid held high with codes 4'b0000 then 4'b1111 -> second accept on the first IDLE cycle (the done cycle); no overlap; fila=0001 for col=0001, then fila=1000 for col=1000.
5. Reset mid-HOLD: assert rst at HOLD cycle 5 -> next cycle fila=0, busy=0, key_ready=1, done stays 0.
6. Parameter override BOUNCE_CYCLES=0, GAP_CYCLES=0, HOLD_CYCLES=3 -> pressed=1 for exactly 3 cycles after accept, busy for 3 cycles, done in cycle 4.

Source files
------------

// File: rtl/teclado_pkg.sv
// Shared definitions for the 4x4 keypad emulator and its scanner counterpart.
package teclado_pkg;

    localparam int unsigned KEYPAD_ROWS = 4;
    localparam int unsigned KEYPAD_COLS = 4;
    localparam int unsigned KEY_IDX_W   = 2;
    localparam int unsigned KEY_CODE_W  = 2 * KEY_IDX_W;

    // Press sequence, in playback order
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        BOUNCE_IN  = 3'd1,
        HOLD       = 3'd2,
        BOUNCE_OUT = 3'd3,
        GAP        = 3'd4
    } emu_state_t;

    typedef struct packed {
        logic [KEY_IDX_W-1:0] row;
        logic [KEY_IDX_W-1:0] col;
    } key_code_t;

    function automatic logic [KEYPAD_ROWS-1:0] row_onehot(input logic [KEY_IDX_W-1:0] r);
        logic [KEYPAD_ROWS-1:0] oh;
        oh    = '0;
        oh[r] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/module_teclado_fase_timer.sv
// Phase timer: counts cycles within one emulator phase and tracks bounce parity.
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : restart the phase at k=0 on the next edge
//   last_i       : terminal count (phase length - 1) of the phase being entered
//   tc_o         : current cycle is the last of the phase
//   tog_next_o   : floor(k/BOUNCE_PERIOD) parity of the next cycle (combinational)
module module_teclado_fase_timer #(
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned BOUNCE_PERIOD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] last_i,
    output logic             tc_o,
    output logic             tog_next_o
);

    localparam int unsigned PER_W = $clog2((BOUNCE_PERIOD > 2) ? BOUNCE_PERIOD : 2);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(BOUNCE_PERIOD - 1);

    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [PER_W-1:0] p_q, p_d;
    logic             tog_q, tog_d;

    // Next count; the parity bit flips every BOUNCE_PERIOD cycles
    always_comb begin
        k_d    = k_q + CNT_W'(1);
        last_d = last_q;
        p_d    = (p_q == PER_LAST) ? '0 : p_q + PER_W'(1);
        tog_d  = (p_q == PER_LAST) ? ~tog_q : tog_q;
        if (load_i) begin
            k_d    = '0;
            last_d = last_i;
            p_d    = '0;
            tog_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q    <= '0;
            last_q <= '0;
            p_q    <= '0;
            tog_q  <= 1'b0;
        end else begin
            k_q    <= k_d;
            last_q <= last_d;
            p_q    <= p_d;
            tog_q  <= tog_d;
        end
    end

    assign tc_o       = (k_q == last_q);
    assign tog_next_o = tog_d;

endmodule

// File: rtl/module_teclado_emulador.sv
// 4x4 matrix-keypad emulator: plays a timed, bouncing key press onto the row
// lines in response to the scanner's column drive.
//   clk, rst   : clock, synchronous active-high reset
//   key_code   : requested key {row[1:0], col[1:0]}
//   key_valid  : request valid; key_ready : idle, request accepted on valid&ready
//   col        : scanner column drive (active-high)
//   fila       : row sense (active-high, combinational from state and col)
//   pressed    : contact state; busy : request in progress
//   done       : one-cycle pulse on the first IDLE cycle after a request
module module_teclado_emulador
    import teclado_pkg::*;
#(
    parameter int unsigned BOUNCE_CYCLES = 8,
    parameter int unsigned BOUNCE_PERIOD = 2,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned GAP_CYCLES    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KEY_CODE_W-1:0]  key_code,
    input  logic                   key_valid,
    output logic                   key_ready,
    input  logic [KEYPAD_COLS-1:0] col,
    output logic [KEYPAD_ROWS-1:0] fila,
    output logic                   pressed,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned MAX_BH  = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_ALL = (MAX_BH > GAP_CYCLES) ? MAX_BH : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2((MAX_ALL > 2) ? MAX_ALL : 2);

    localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);
    localparam bit HAS_GAP    = (GAP_CYCLES > 0);

    localparam logic [CNT_W-1:0] BOUNCE_LAST = HAS_BOUNCE ? CNT_W'(BOUNCE_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : '0;

    emu_state_t       state_q, state_d;
    key_code_t        code_q, code_d;
    logic             contact_q, contact_d;
    logic             busy_q, ready_q, done_q;
    logic             load;
    logic [CNT_W-1:0] last;
    logic             tc;
    logic             tog_next;

    module_teclado_fase_timer #(
        .CNT_W        (CNT_W),
        .BOUNCE_PERIOD(BOUNCE_PERIOD)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .last_i    (last),
        .tc_o      (tc),
        .tog_next_o(tog_next)
    );

    // Next state and request latch; zero-length phases are skipped
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (key_valid) begin
                    code_d  = key_code_t'(key_code);
                    state_d = HAS_BOUNCE ? BOUNCE_IN : HOLD;
                end
            end
            BOUNCE_IN:  if (tc) state_d = HOLD;
            HOLD:       if (tc) state_d = HAS_BOUNCE ? BOUNCE_OUT : (HAS_GAP ? GAP : IDLE);
            BOUNCE_OUT: if (tc) state_d = HAS_GAP ? GAP : IDLE;
            GAP:        if (tc) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        // Timer restarts on every state entry and is parked at zero while idle
        load = (state_d != state_q) || (state_q == IDLE);
    end

    // Contact level and phase length for the cycle being entered
    always_comb begin
        contact_d = 1'b0;
        last      = '0;
        unique case (state_d)
            BOUNCE_IN: begin
                last      = BOUNCE_LAST;
                contact_d = ~tog_next;
            end
            HOLD: begin
                last      = HOLD_LAST;
                contact_d = 1'b1;
            end
            BOUNCE_OUT: begin
                last      = BOUNCE_LAST;
                contact_d = tog_next;
            end
            GAP:     last = GAP_LAST;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= '0;
            contact_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            contact_q <= contact_d;
            busy_q    <= (state_d != IDLE);
            ready_q   <= (state_d == IDLE);
            done_q    <= (state_q != IDLE) && (state_d == IDLE);
        end
    end

    // Row sense follows the scanner's column drive within the same cycle
    always_comb begin
        fila = '0;
        if (contact_q && col[code_q.col]) begin
            fila = row_onehot(code_q.row);
        end
    end

    assign pressed   = contact_q;
    assign busy      = busy_q;
    assign key_ready = ready_q;
    assign done      = done_q;

endmodule

// File: tb/tb_module_teclado_emulador.sv
module tb_module_teclado_emulador;

    localparam int B     = 8;
    localparam int P     = 2;
    localparam int H     = 16;
    localparam int G     = 8;
    localparam int TOTAL = 2 * B + H + G;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, key_valid, key_ready, pressed, busy, done;
    logic [3:0] key_code, col, fila;

    logic       rst2, kv2, kr2, pr2, bs2, dn2;
    logic [3:0] kc2, col2, fila2;

    module_teclado_emulador dut (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
        .key_ready(key_ready), .col(col), .fila(fila), .pressed(pressed),
        .busy(busy), .done(done)
    );

    module_teclado_emulador #(
        .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(2), .HOLD_CYCLES(3), .GAP_CYCLES(0)
    ) dut2 (
        .clk(clk), .rst(rst2), .key_code(kc2), .key_valid(kv2),
        .key_ready(kr2), .col(col2), .fila(fila2), .pressed(pr2),
        .busy(bs2), .done(dn2)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: m_t is the 1-based cycle index within a request (0 = idle)
    int         m_t = 0;
    logic [3:0] m_code = 4'b0;
    logic       m_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_code = 4'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_t == 0) begin
                if (key_valid) begin
                    m_t = 1; m_code = key_code;
                end
            end else if (m_t == TOTAL) begin
                m_t = 0; m_done = 1'b1;
            end else begin
                m_t = m_t + 1;
            end
        end
    end

    function automatic logic model_contact(input int t);
        if (t == 0)         return 1'b0;
        if (t <= B)         return (((t - 1) / P) % 2) == 0;
        if (t <= B + H)     return 1'b1;
        if (t <= 2 * B + H) return (((t - B - H - 1) / P) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        logic       c;
        logic [3:0] ef;
        c  = model_contact(m_t);
        ef = (c && col[m_code[1:0]]) ? 4'(1 << m_code[3:2]) : 4'b0000;
        chk({tag, " fila"},    fila,              ef);
        chk({tag, " pressed"}, {3'b0, pressed},   {3'b0, c});
        chk({tag, " busy"},    {3'b0, busy},      {3'b0, (m_t != 0)});
        chk({tag, " ready"},   {3'b0, key_ready}, {3'b0, (m_t == 0)});
        chk({tag, " done"},    {3'b0, done},      {3'b0, m_done});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < TOTAL + 10 && !(key_ready && !done); i++) begin
            tick();
            chk_model(tag);
        end
        chk({tag, " reached idle"}, {3'b0, key_ready}, 4'b0001);
    endtask

    typedef struct {
        logic [3:0] col;
        logic [3:0] fila;
    } scan_vec_t;

    typedef struct {
        logic p;
        logic b;
        logic d;
    } short_vec_t;

    scan_vec_t  sv[6];
    short_vec_t shv[5];
    logic [3:0] bin_exp[8];
    logic [3:0] bout_exp[8];

    initial begin
        int busy_cnt;
        logic [3:0] e;

        sv[0] = '{4'b0001, 4'b0000};
        sv[1] = '{4'b0010, 4'b1000};
        sv[2] = '{4'b0100, 4'b0000};
        sv[3] = '{4'b1000, 4'b0000};
        sv[4] = '{4'b0000, 4'b0000};
        sv[5] = '{4'b1111, 4'b1000};
        shv[0] = '{1'b1, 1'b1, 1'b0};
        shv[1] = '{1'b1, 1'b1, 1'b0};
        shv[2] = '{1'b1, 1'b1, 1'b0};
        shv[3] = '{1'b0, 1'b0, 1'b1};
        shv[4] = '{1'b0, 1'b0, 1'b0};
        bin_exp  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        bout_exp = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010};

        rst = 1'b1; key_valid = 1'b1; key_code = 4'b0110; col = 4'b0100;
        rst2 = 1'b1; kv2 = 1'b0; kc2 = 4'b0; col2 = 4'b0;

        // Reset held with a pending request
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_model("rst");
            chk("rst fila", fila, 4'b0000);
            chk("rst busy", {3'b0, busy}, 4'b0000);
            chk("rst ready", {3'b0, key_ready}, 4'b0001);
            chk("rst done", {3'b0, done}, 4'b0000);
        end

        // Basic press with default timing
        rst = 1'b0;
        busy_cnt = 0;
        for (int n = 1; n <= TOTAL + 1; n++) begin
            tick();
            if (n == 1) key_valid = 1'b0;
            chk_model("basic");
            if (busy) busy_cnt++;
            if (n <= B)              e = bin_exp[n - 1];
            else if (n <= B + H)     e = 4'b0010;
            else if (n <= 2 * B + H) e = bout_exp[n - B - H - 1];
            else                     e = 4'b0000;
            chk("basic fila seq", fila, e);
            if (n == TOTAL + 1) chk("basic done pulse", {3'b0, done}, 4'b0001);
        end
        chk("basic busy cycles", 4'(busy_cnt >> 2), 4'(40 >> 2));
        chk("basic busy cycles lsb", 4'(busy_cnt & 3), 4'b0000);

        // Column scanning response during HOLD
        key_code = 4'b1101; key_valid = 1'b1; col = 4'b0000;
        tick(); chk_model("scan accept");
        key_valid = 1'b0;
        for (int n = 2; n <= B + 2; n++) begin
            tick(); chk_model("scan pre");
        end
        for (int i = 0; i < 6; i++) begin
            col = sv[i].col;
            #1;
            chk("scan fila", fila, sv[i].fila);
            chk_model("scan");
            tick();
            chk("scan fila held", fila, sv[i].fila);
        end
        wait_idle("scan tail");

        // Back-to-back requests with key_valid held high
        key_code = 4'b0000; key_valid = 1'b1; col = 4'b0001;
        tick(); chk_model("b2b n1");
        key_code = 4'b1111;
        for (int n = 2; n <= TOTAL + 1; n++) begin
            tick(); chk_model("b2b");
            if (n == B + 4) chk("b2b first fila", fila, 4'b0001);
            if (n == TOTAL + 1) begin
                chk("b2b done", {3'b0, done}, 4'b0001);
                chk("b2b ready on done", {3'b0, key_ready}, 4'b0001);
            end
        end
        col = 4'b1000;
        tick(); chk_model("b2b second");
        chk("b2b second busy", {3'b0, busy}, 4'b0001);
        chk("b2b second fila", fila, 4'b1000);
        key_valid = 1'b0;
        wait_idle("b2b tail");

        // Reset during HOLD aborts without a done pulse
        key_code = 4'($urandom_range(0, 15)); key_valid = 1'b1; col = 4'b1111;
        tick(); chk_model("abort accept");
        key_valid = 1'b0;
        for (int n = 2; n <= B + 6; n++) begin
            tick(); chk_model("abort pre");
        end
        chk("abort in hold", {3'b0, pressed}, 4'b0001);
        rst = 1'b1;
        tick(); chk_model("abort");
        chk("abort fila", fila, 4'b0000);
        chk("abort busy", {3'b0, busy}, 4'b0000);
        chk("abort ready", {3'b0, key_ready}, 4'b0001);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_model("abort after");
            chk("abort no done", {3'b0, done}, 4'b0000);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            key_valid = ($urandom_range(0, 3) == 0);
            key_code  = 4'($urandom_range(0, 15));
            col       = 4'($urandom_range(0, 15));
            tick(); chk_model("rand");
            if ($urandom_range(0, 3) == 0) begin
                col = 4'($urandom_range(0, 15));
                #1; chk_model("rand col");
            end
        end
        rst = 1'b0; key_valid = 1'b0;

        // Short configuration: no bounce, no gap, 3-cycle hold
        tick();
        chk("short rst ready", {3'b0, kr2}, 4'b0001);
        chk("short rst done", {3'b0, dn2}, 4'b0000);
        rst2 = 1'b0; kv2 = 1'b1; kc2 = 4'b1010; col2 = 4'b0100;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (n == 0) kv2 = 1'b0;
            chk("short pressed", {3'b0, pr2}, {3'b0, shv[n].p});
            chk("short busy", {3'b0, bs2}, {3'b0, shv[n].b});
            chk("short done", {3'b0, dn2}, {3'b0, shv[n].d});
            chk("short fila", fila2, shv[n].p ? 4'b0100 : 4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
